imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_ext_pkg.sv | 19 +
 rtl/imm_ext_core.sv | 38 +++
 rtl/imm_extend_pipe.sv | 129 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: mode encoding and occupancy state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMMX_SIGN  = 2'b00,
    IMMX_ZERO  = 2'b01,
    IMMX_UPPER = 2'b10,
    IMMX_ONES  = 2'b11
  } immx_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension (sign / zero / upper / ones) from IN_W to OUT_W bits.
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller registers the result.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  generate
    if (OUT_W == IN_W) begin : g_pass
      // No room to extend: every mode is a straight pass-through.
      logic unused_mode;
      assign unused_mode = ^in_mode;
      assign ext_data    = in_data;
    end else begin : g_ext
      localparam int PAD = OUT_W - IN_W;

      // Select the fill pattern for the bits that the immediate does not cover.
      always_comb begin
        ext_data = {{PAD{in_data[IN_W-1]}}, in_data};
        case (immx_mode_e'(in_mode))
          IMMX_SIGN:  ext_data = {{PAD{in_data[IN_W-1]}}, in_data};
          IMMX_ZERO:  ext_data = {{PAD{1'b0}}, in_data};
          IMMX_UPPER: ext_data = {in_data, {PAD{1'b0}}};
          IMMX_ONES:  ext_data = {{PAD{1'b1}}, in_data};
          default:    ext_data = {{PAD{in_data[IN_W-1]}}, in_data};
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry (main + skid) output buffer; IMMX_COUNT_EN adds xfer_count.
// Latency: 1 cycle from input transfer to out_valid when empty.
// Backpressure: in_ready is registered and drops only when both entries are full.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMMX_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  occ_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] main_q, skid_q, ext_data;
  logic             in_xfer, out_xfer;
  logic             load_main_ext, load_main_skid, load_skid;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Occupancy next state and data-register steering; handshake flags follow the next state.
  always_comb begin
    state_d        = state_q;
    load_main_ext  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          state_d       = OCC_ONE;
          load_main_ext = 1'b1;
        end
      end
      OCC_ONE: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_d   = OCC_TWO;
            load_skid = 1'b1;
          end
          2'b01: state_d = OCC_EMPTY;
          2'b11: load_main_ext = 1'b1;
          default: state_d = OCC_ONE;
        endcase
      end
      OCC_TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          state_d        = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    in_ready_d  = (state_d != OCC_TWO);
    out_valid_d = (state_d != OCC_EMPTY);
  end

  // Occupancy state and registered handshake outputs; reset drops them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Result storage: main feeds out_data, skid catches the one extra result under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_ext) begin
        main_q <= ext_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= ext_data;
      end
    end
  end

`ifdef IMMX_COUNT_EN
  logic [15:0] count_q;

  // Free-running count of accepted inputs, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (in_xfer) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign xfer_count = count_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe (32-bit default build plus a 16/16 pass-through instance).
// Latency: n/a.
// Backpressure: exercised through out_ready stalls.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        in2_valid, in2_ready, out2_valid;
  logic [15:0] in2_data, out2_data;
  logic [1:0]  in2_mode;

`ifdef IMMX_COUNT_EN
  logic [15:0] xfer_count, xfer_count2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef IMMX_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(16)) dut_eq (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in2_valid),
    .in_ready   (in2_ready),
    .in_data    (in2_data),
    .in_mode    (in2_mode),
    .out_valid  (out2_valid),
    .out_ready  (1'b1),
    .out_data   (out2_data)
`ifdef IMMX_COUNT_EN
    ,
    .xfer_count (xfer_count2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] d);
    case (m)
      2'b00:   return {{16{d[15]}}, d};
      2'b01:   return {16'h0000, d};
      2'b10:   return {d, 16'h0000};
      default: return {16'hFFFF, d};
    endcase
  endfunction

  // One input with out_ready high: visible after one edge, gone after the next.
  task automatic send_one(input string tag, input logic [1:0] m, input logic [15:0] d,
                          input logic [31:0] exp);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = 16'h5A5A; in_mode = 2'b11;
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_dat"}, out_data, exp);
    step();
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_data = '0; in2_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
`ifdef IMMX_COUNT_EN
    chk("rst_count", xfer_count, 16'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Mode vectors, hand computed.
    send_one("sign_8001",  2'b00, 16'h8001, 32'hFFFF8001);
    send_one("zero_8001",  2'b01, 16'h8001, 32'h00008001);
    send_one("upper_1234", 2'b10, 16'h1234, 32'h12340000);
    send_one("ones_0005",  2'b11, 16'h0005, 32'hFFFF0005);
    send_one("sign_7fff",  2'b00, 16'h7FFF, 32'h00007FFF);
    send_one("ones_ffff",  2'b11, 16'hFFFF, 32'hFFFFFFFF);

    // Equal widths: every mode passes the value through.
    for (int m = 0; m < 4; m++) begin
      in2_valid = 1'b1; in2_mode = 2'(m); in2_data = 16'hABCD;
      step();
      in2_valid = 1'b0; in2_data = 16'h0000;
      chk($sformatf("eq_mode%0d_vld", m), out2_valid, 1'b1);
      chk($sformatf("eq_mode%0d_dat", m), out2_data, 16'hABCD);
    end
    step();

    // Backpressure: three offers with the output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_data = 16'h1111;
    step();
    chk("bp_first_rdy", in_ready, 1'b1);
    chk("bp_first_dat", out_data, 32'h00001111);
    in_data = 16'h2222;
    step();
    chk("bp_second_rdy", in_ready, 1'b0);
    chk("bp_second_dat", out_data, 32'h00001111);
    in_data = 16'h3333;
    step();
    chk("bp_third_rdy", in_ready, 1'b0);
    chk("bp_hold_dat", out_data, 32'h00001111);
    chk("bp_hold_vld", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_rel_second", out_data, 32'h00002222);
    chk("bp_rel_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_rel_third", out_data, 32'h00003333);
    chk("bp_rel_third_vld", out_valid, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Continuous streaming: one result per cycle, never stalling the input.
    for (int i = 0; i < 100; i++) begin
      logic [15:0] d;
      logic [1:0]  m;
      d = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b1;
      step();
      chk($sformatf("stream%0d_rdy", i), in_ready, 1'b1);
      chk($sformatf("stream%0d_vld", i), out_valid, 1'b1);
      chk($sformatf("stream%0d_dat", i), out_data, ref_ext(m, d));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", out_valid, 1'b0);

    // Fill both entries, then reset between edges.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'hDEAD;
    step();
    in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    chk("two_rdy", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_vld", i), out_valid, 1'b0);
    end
    send_one("post_rst_new", 2'b01, 16'h00C3, 32'h000000C3);

`ifdef IMMX_COUNT_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cnt_rst", xfer_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h0001; out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", xfer_count, 16'hFFFF);
    step();
    chk("cnt_wrap", xfer_count, 16'h0000);
    step();
    chk("cnt_65537", xfer_count, 16'h0001);
    in_valid = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
